// File: rtl/div_pkg.sv
// Shared types and constants for the non-restoring 32/16 divider.
package div_pkg;

  // Divider sequencing: accept, iterate, correct remainder, present result.
  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

  localparam int unsigned DefDw = 32;
  localparam int unsigned DefVw = 16;

  // Iteration counter covers 0 .. DW-1.
  localparam int unsigned CntW = $clog2(DefDw);

  // Result reported when the divisor is zero.
  localparam logic [DefDw-1:0] DbzQuotient  = {DefDw{1'b1}};
  localparam logic [DefVw-1:0] DbzRemainder = '0;

endpackage

// File: rtl/div_if.sv
// Operand / result handshake bundle for the divider.
interface div_if
  import div_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned VW = DefVw
) ();

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  // Requester side: supplies operands, consumes results.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/addsub17.sv
// 17-bit Kogge-Stone prefix adder/subtractor: sum = a + b (sub=0) or a - b (sub=1).
module addsub17 (
  input  logic [16:0] a_i,
  input  logic [16:0] b_i,
  input  logic        sub_i,
  output logic [16:0] sum_o
);

  localparam int unsigned Width  = 17;
  localparam int unsigned Levels = 5;  // spans 1,2,4,8,16 cover 17 bits

  logic [Width-1:0] b_x;
  logic [Width-1:0] p0;
  logic [Width-1:0] gg [Levels+1];
  logic [Width-1:0] pp [Levels+1];

  // Prefix tree; carry-in folded into bit 0 generate so subtract is a + ~b + 1.
  always_comb begin
    b_x = b_i ^ {Width{sub_i}};
    p0  = a_i ^ b_x;
    for (int l = 0; l <= int'(Levels); l++) begin
      gg[l] = '0;
      pp[l] = '0;
    end
    gg[0]    = a_i & b_x;
    gg[0][0] = (a_i[0] & b_x[0]) | (p0[0] & sub_i);
    pp[0]    = p0;
    for (int l = 1; l <= int'(Levels); l++) begin
      for (int i = 0; i < int'(Width); i++) begin
        if (i >= (1 << (l - 1))) begin
          gg[l][i] = gg[l-1][i] | (pp[l-1][i] & gg[l-1][i - (1 << (l - 1))]);
          pp[l][i] = pp[l-1][i] & pp[l-1][i - (1 << (l - 1))];
        end else begin
          gg[l][i] = gg[l-1][i];
          pp[l][i] = pp[l-1][i];
        end
      end
    end
  end

  // Carry into bit i is the group generate of bits i-1..0 (plus carry-in).
  assign sum_o = p0 ^ {gg[Levels][Width-2:0], sub_i};

endmodule

// File: rtl/nonrestoring_div32by16.sv
// Sequential unsigned 32/16 divider, non-restoring radix-2, one quotient bit per cycle.
module nonrestoring_div32by16
  import div_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned VW = DefVw  // shared adder is fixed at VW+1 = 17 bits
) (
  input logic  clk,
  input logic  rst_n,
  div_if.slave bus
);

  div_state_e      state_q, state_d;
  logic [VW:0]     r_q, r_d;      // signed partial remainder
  logic [DW-1:0]   q_q, q_d;      // dividend shifting out, quotient shifting in
  logic [VW-1:0]   d_q, d_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [VW-1:0]   rem_q, rem_d;
  logic            dbz_q, dbz_d;

  logic [VW:0]     as_a, as_b, as_sum;
  logic            as_sub;

  // Shared adder operands: shifted remainder +/- D in CALC, R + D in FIX.
  always_comb begin
    as_b   = {1'b0, d_q};
    as_a   = r_q;
    as_sub = 1'b0;
    if (state_q == StCalc) begin
      as_a   = {r_q[VW-1:0], q_q[DW-1]};
      as_sub = ~r_q[VW];
    end
  end

  addsub17 u_addsub (
    .a_i   (as_a),
    .b_i   (as_b),
    .sub_i (as_sub),
    .sum_o (as_sum)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          q_d   = bus.dividend;
          d_d   = bus.divisor;
          r_d   = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            quo_d   = DbzQuotient;
            rem_d   = DbzRemainder;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        // Truncating the shift is safe: the true post-add remainder lies in [-D, D).
        r_d   = as_sum;
        q_d   = {q_q[DW-2:0], ~as_sum[VW]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(DW - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // Negative final remainder gets one restoring add of D.
        r_d     = r_q[VW] ? as_sum : r_q;
        rem_d   = r_q[VW] ? as_sum[VW-1:0] : r_q[VW-1:0];
        quo_d   = q_q;
        dbz_d   = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight division.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // in_ready is held low while reset is asserted.
  assign bus.in_ready    = rst_n & (state_q == StIdle);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_div32by16.sv
// Self-checking bench for nonrestoring_div32by16 against an arithmetic reference model.
module tb_nonrestoring_div32by16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  div_if #(.DW(32), .VW(16)) bus ();

  nonrestoring_div32by16 #(.DW(32), .VW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, all-ones/zero on divide by zero.
  function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output logic z);
    logic [31:0] rr;
    if (b == 16'd0) begin
      q = 32'hFFFF_FFFF;
      r = 16'd0;
      z = 1'b1;
    end else begin
      q  = a / {16'd0, b};
      rr = a % {16'd0, b};
      r  = rr[15:0];
      z  = 1'b0;
    end
  endfunction

  // Drive one operand pair, wait for the result; edges = clock edges after accept.
  task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                        output logic [31:0] q, output logic [15:0] r, output logic z,
                        output int edges, output bit timeout);
    int n = 0;
    timeout = 1'b0;
    edges   = 0;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      timeout = 1'b1;
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      while (!bus.out_valid && edges < 100) begin
        @(posedge clk); #1;
        edges++;
      end
      timeout = !bus.out_valid;
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
  endtask

  // Consume the pending result after a number of stall cycles.
  task automatic release_out(input int stall);
    bus.out_ready = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready_low got=%b exp=0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.quotient !== 32'd0 || bus.remainder !== 16'd0 ||
        bus.div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b q=%0h r=%0h z=%b exp=0", bus.out_valid,
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready_high got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [6];
    logic [15:0] vb [6];
    logic [31:0] vq [6];
    logic [15:0] vr [6];
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
    int          edges;
    bit          to;
    va[0] = 32'd12001300;   vb[0] = 16'd1002;   vq[0] = 32'd11977;       vr[0] = 16'd346;
    va[1] = 32'd1680000;    vb[1] = 16'd1400;   vq[1] = 32'd1200;        vr[1] = 16'd0;
    va[2] = 32'd1680000;    vb[2] = 16'd1200;   vq[2] = 32'd1400;        vr[2] = 16'd0;
    va[3] = 32'hFFFF_FFFF;  vb[3] = 16'h0001;   vq[3] = 32'hFFFF_FFFF;   vr[3] = 16'd0;
    va[4] = 32'hFFFF_FFFF;  vb[4] = 16'hFFFF;   vq[4] = 32'h0001_0001;   vr[4] = 16'd0;
    va[5] = 32'd5;          vb[5] = 16'd7;      vq[5] = 32'd0;           vr[5] = 16'd5;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], q, r, z, edges, to);
      checks++;
      if (to || q !== vq[i] || r !== vr[i] || z !== 1'b0) begin
        failures++;
        $display("FAIL directed_%0d got q=%0d r=%0d z=%b to=%b exp q=%0d r=%0d z=0",
                 i, q, r, z, to, vq[i], vr[i]);
      end
      checks++;
      if (edges !== 33) begin
        failures++; $display("FAIL directed_latency_%0d got=%0d exp=33", i, edges);
      end
      release_out(0);
    end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
    int          edges;
    bit          to;
    run_op(32'd1234, 16'd0, q, r, z, edges, to);
    checks++;
    if (to || q !== 32'hFFFF_FFFF || r !== 16'd0 || z !== 1'b1) begin
      failures++;
      $display("FAIL dbz_result got q=%0h r=%0h z=%b to=%b exp q=ffffffff r=0 z=1",
               q, r, z, to);
    end
    checks++;
    if (edges !== 0) begin
      failures++; $display("FAIL dbz_latency got=%0d exp=0 extra edges", edges);
    end
    release_out(0);
    run_op(32'd1680000, 16'd1400, q, r, z, edges, to);
    checks++;
    if (to || q !== 32'd1200 || r !== 16'd0 || z !== 1'b0) begin
      failures++;
      $display("FAIL dbz_clears got q=%0d r=%0d z=%b exp q=1200 r=0 z=0", q, r, z);
    end
    release_out(0);
  endtask

  task automatic test_backpressure();
    logic [31:0] q, eq;
    logic [15:0] r, er;
    logic        z, ez;
    int          edges;
    bit          to;
    ref_div(32'd987654321, 16'd12345, eq, er, ez);
    bus.out_ready = 1'b0;
    run_op(32'd987654321, 16'd12345, q, r, z, edges, to);
    checks++;
    if (to || q !== eq || r !== er || z !== ez) begin
      failures++;
      $display("FAIL bp_result got q=%0d r=%0d z=%b exp q=%0d r=%0d z=%b", q, r, z, eq, er, ez);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== eq ||
          bus.remainder !== er) begin
        failures++;
        $display("FAIL bp_hold_%0d got v=%b rdy=%b q=%0d r=%0d exp v=1 rdy=0 q=%0d r=%0d",
                 c, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, eq, er);
      end
    end
    release_out(0);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_after got rdy=%b v=%b exp rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_busy_ignore();
    int  n = 0;
    bit  extra = 1'b0;
    bus.dividend = 32'd1000;
    bus.divisor  = 16'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus.dividend = 32'd60000;
    bus.divisor  = 16'd5;
    bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL busy_in_ready got=%b exp=0", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.quotient !== 32'd333 || bus.remainder !== 16'd1) begin
      failures++;
      $display("FAIL busy_result got v=%b q=%0d r=%0d exp v=1 q=333 r=1",
               bus.out_valid, bus.quotient, bus.remainder);
    end
    release_out(0);
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid) extra = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (extra) begin
      failures++; $display("FAIL busy_not_captured got extra_result=1 exp=0");
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
    int          edges;
    bit          to;
    bus.dividend = 32'd12001300;
    bus.divisor  = 16'd1002;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.quotient !== 32'd0 ||
        bus.remainder !== 16'd0 || bus.div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL midreset_low got rdy=%b v=%b q=%0h r=%0h z=%b exp all 0", bus.in_ready,
               bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 32'd0 ||
        bus.remainder !== 16'd0) begin
      failures++;
      $display("FAIL midreset_release got rdy=%b v=%b q=%0h r=%0h exp rdy=1 v=0 q=0 r=0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder);
    end
    run_op(32'd100, 16'd7, q, r, z, edges, to);
    checks++;
    if (to || q !== 32'd14 || r !== 16'd2 || z !== 1'b0) begin
      failures++;
      $display("FAIL midreset_next got q=%0d r=%0d z=%b exp q=14 r=2 z=0", q, r, z);
    end
    release_out(0);
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int results = 0;
    bus.dividend  = 32'd12001300;
    bus.divisor   = 16'd1002;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 120; c++) begin
      if (bus.in_ready) acc.push_back(c);
      if (bus.out_valid) begin
        results++;
        checks++;
        if (bus.quotient !== 32'd11977 || bus.remainder !== 16'd346) begin
          failures++;
          $display("FAIL b2b_result got q=%0d r=%0d exp q=11977 r=346",
                   bus.quotient, bus.remainder);
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    checks++;
    if (acc.size() != 4 || results != 3) begin
      failures++;
      $display("FAIL b2b_counts got accepts=%0d results=%0d exp 4 and 3", acc.size(), results);
    end
    for (int k = 1; k < acc.size(); k++) begin
      checks++;
      if (acc[k] - acc[k-1] != 35) begin
        failures++; $display("FAIL b2b_spacing got=%0d exp=35", acc[k] - acc[k-1]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, q, eq;
    logic [15:0] b, r, er;
    logic        z, ez;
    int          edges, sel;
    bit          to;
    for (int i = 0; i < 1200; i++) begin
      sel = int'($urandom_range(0, 15));
      if (sel == 0)     b = 16'd0;
      else if (sel < 4) b = 16'($urandom_range(1, 15));
      else              b = 16'($urandom);
      a = (sel == 5) ? 32'($urandom_range(0, 70000)) : $urandom;
      ref_div(a, b, eq, er, ez);
      run_op(a, b, q, r, z, edges, to);
      checks++;
      if (to || q !== eq || r !== er || z !== ez) begin
        failures++;
        $display("FAIL random_%0d %0d/%0d got q=%0d r=%0d z=%b to=%b exp q=%0d r=%0d z=%b",
                 i, a, b, q, r, z, to, eq, er, ez);
        if (to) break;
      end
      release_out(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_div_by_zero();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
